// File: rtl/fxp_pkg.sv
// fxp_pkg: rounding-mode encoding shared by the fixed-point multiplier
package fxp_pkg;
  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,
    RND_HALF_UP   = 2'b01,
    RND_HALF_EVEN = 2'b10,
    RND_RSVD      = 2'b11
  } rnd_t;
endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: align the product fraction to the result format, round, then saturate or wrap
module fxp_round_sat import fxp_pkg::*; #(
  parameter int PI  = 8,
  parameter int PF  = 8,
  parameter int WI0 = 4,
  parameter int WF0 = 4
) (
  input  logic signed [PI+PF-1:0]   p,
  input  rnd_t                      rnd,
  input  logic                      sat,
  output logic        [WI0+WF0-1:0] res,
  output logic                      ovf
);
  localparam int PW = PI + PF;
  localparam int OW = WI0 + WF0;
  localparam int XW = PW + OW + WF0 + 2;
  localparam logic signed [XW-1:0] MAXV = (XW'(1) << (OW-1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;
  logic signed [XW-1:0] pe, r;
  assign pe = {{(XW-PW){p[PW-1]}}, p};
  generate
    if (WF0 >= PF) begin : g_ext
      assign r = pe <<< (WF0 - PF);
    end else begin : g_drop
      localparam int D = PF - WF0;
      localparam logic [XW-1:0] HALF = XW'(1) << (D-1);
      logic signed [XW-1:0] q;
      logic [XW-1:0] rem;
      logic up;
      always_comb begin
        q = pe >>> D;
        rem = pe & ((HALF << 1) - XW'(1));
        up = rnd == RND_HALF_UP ? rem >= HALF :
             rnd == RND_HALF_EVEN ? (rem > HALF || (rem == HALF && q[0])) : 1'b0;
        r = q + XW'(up);
      end
    end
  endgenerate
  // range check on the wide value catches both lost integer bits and rounding carry-out
  always_comb begin
    ovf = r > MAXV || r < MINV;
    res = ovf && sat ? (p[PW-1] ? MINV[OW-1:0] : MAXV[OW-1:0]) : r[OW-1:0];
  end
endmodule

// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: three-stage signed fixed-point multiplier with rounding, saturation and overflow count
module fxp_mult_pipe import fxp_pkg::*; #(
  parameter int WI1 = 4,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 4,
  parameter int WI0 = 4,
  parameter int WF0 = 4,
  parameter int CW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in_a,
  input  logic [WI2+WF2-1:0]   in_b,
  input  logic [1:0]           in_rnd,
  input  logic                 in_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WI0+WF0-1:0]   out_data,
  output logic                 out_ovf,
  output logic [CW-1:0]        ovf_cnt,
  input  logic                 ovf_clr
);
  localparam int NA = WI1 + WF1;
  localparam int NB = WI2 + WF2;
  localparam int PW = NA + NB;
  localparam int OW = WI0 + WF0;
  logic v1, v2, sat1, sat2, ovf;
  rnd_t rnd1, rnd2;
  logic signed [NA-1:0] a1;
  logic signed [NB-1:0] b1;
  logic signed [PW-1:0] p2;
  logic [OW-1:0] res;
  assign in_ready = !(out_valid && !out_ready);
  // one shared enable: the whole pipe advances or holds together
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, out_valid, sat1, sat2, out_ovf} <= '0;
      rnd1 <= RND_TRUNC;
      rnd2 <= RND_TRUNC;
      a1 <= '0;
      b1 <= '0;
      p2 <= '0;
      out_data <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      a1 <= in_a;
      b1 <= in_b;
      rnd1 <= rnd_t'(in_rnd);
      sat1 <= in_sat;
      v2 <= v1;
      p2 <= PW'(a1) * PW'(b1);
      rnd2 <= rnd1;
      sat2 <= sat1;
      out_valid <= v2;
      out_data <= res;
      out_ovf <= ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) ovf_cnt <= '0;
    else if (out_valid && out_ready && out_ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + CW'(1);
  end
  fxp_round_sat #(.PI(WI1+WI2), .PF(WF1+WF2), .WI0(WI0), .WF0(WF0)) u_rs (
    .p(p2), .rnd(rnd2), .sat(sat2), .res(res), .ovf(ovf)
  );
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb_fxp_mult_pipe: directed Q4.4 vectors with hand-computed results, stall and reset scenarios
module tb_fxp_mult_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sat = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [1:0] in_rnd = '0;
  logic in_ready, out_valid, out_ovf;
  logic [7:0] out_data;
  logic [15:0] ovf_cnt;
  int n_chk = 0, n_fail = 0;
  int sent, got;
  logic seen;
  logic [7:0] exp_s [8];

  fxp_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_rnd(in_rnd), .in_sat(in_sat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] r, input logic s,
                      input logic [7:0] ed, input logic eo, input string tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_rnd = r; in_sat = s;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk({tag, "_early"}, out_valid, 1'b0);
    cyc();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_ovf"}, out_ovf, eo);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ovf", out_ovf, 1'b0);
    chk("rst_cnt", ovf_cnt, 16'h0);
    rst = 1'b0;
    cyc();
    chk("rst_ready", in_ready, 1'b1);

    beat(8'h18, 8'h18, 2'b00, 1'b1, 8'h24, 1'b0, "mul_1p5sq");
    beat(8'h01, 8'h08, 2'b00, 1'b0, 8'h00, 1'b0, "tie_trunc");
    beat(8'h01, 8'h08, 2'b01, 1'b0, 8'h01, 1'b0, "tie_halfup");
    beat(8'h01, 8'h08, 2'b10, 1'b0, 8'h00, 1'b0, "tie_even0");
    beat(8'h03, 8'h08, 2'b10, 1'b0, 8'h02, 1'b0, "tie_even1");
    beat(8'h01, 8'h08, 2'b11, 1'b0, 8'h00, 1'b0, "rnd_rsvd");
    beat(8'hFF, 8'h08, 2'b00, 1'b0, 8'hFF, 1'b0, "neg_trunc");
    beat(8'hFF, 8'h08, 2'b01, 1'b0, 8'h00, 1'b0, "neg_halfup");
    beat(8'h70, 8'h20, 2'b00, 1'b1, 8'h7F, 1'b1, "ovf_sat");
    beat(8'h70, 8'h20, 2'b00, 1'b0, 8'hE0, 1'b1, "ovf_wrap");
    beat(8'h80, 8'hF0, 2'b00, 1'b1, 8'h7F, 1'b1, "ovf_minsq");
    cyc();
    chk("cnt_three", ovf_cnt, 16'd3);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("cnt_clr", ovf_cnt, 16'd0);
    beat(8'h80, 8'h20, 2'b00, 1'b1, 8'h80, 1'b1, "ovf_negsat");
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("cnt_clr_prio", ovf_cnt, 16'd0);
    beat(8'h70, 8'h20, 2'b00, 1'b0, 8'hE0, 1'b1, "ovf_wrap2");
    cyc();
    chk("cnt_one", ovf_cnt, 16'd1);

    exp_s = '{8'h22, 8'h24, 8'h26, 8'h28, 8'h2A, 8'h2C, 8'h2E, 8'h30};
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid = sent < 8;
      in_a = 8'h11 + 8'(sent);
      in_b = 8'h20;
      in_rnd = 2'b00;
      in_sat = 1'b1;
      #1;
      if (!out_ready && out_valid) chk("stall_ready", in_ready, 1'b0);
      if (out_valid) chk($sformatf("stream_%0d", got), out_data, exp_s[got]);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got++;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, 8);

    repeat (3) cyc();
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h10; in_rnd = 2'b00; in_sat = 1'b0;
    cyc();
    in_a = 8'h20;
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 8'h00);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      cyc();
      seen |= out_valid;
    end
    chk("midrst_dropped", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
